// File: rtl/alu_vector_driver.sv
// alu_vector_driver: LFSR operand source and dual-ALU result cross-checker.
// Optional: define ALU_VECTOR_DRIVER_STOP_ON_FAIL_EN to end a run at the first failing vector.
module alu_vector_driver #(
    parameter int unsigned NUM_VEC    = 16,
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [31:0] SEED       = 32'hACE1_0001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [30:0]  a_o,
    output logic [30:0]  b_o,
    output logic [15:0]  l_o,
    output logic [15:0]  m_o,
    input  logic [255:0] res_x,
    input  logic [255:0] res_y,
    output logic         busy,
    output logic         done,
    output logic [15:0]  vec_idx,
    output logic [15:0]  err_cnt,
    output logic [15:0]  first_fail,
    output logic [7:0]   fail_mask
);
    localparam int unsigned   CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [15:0]   VEC_LAST = 16'(NUM_VEC - 1);
    localparam logic [31:0]   POLY     = 32'h8020_0003;
    localparam logic [15:0]   NO_FAIL  = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   vec_q, vec_d;
    logic [15:0]   err_q, err_d;
    logic [15:0]   ff_q, ff_d;
    logic [7:0]    fm_q, fm_d;
    logic          drv_q, drv_d;

    logic [31:0]   lfsr_next;
    logic [7:0]    mask;
    logic          last_vec;
    logic          stop_fail;

    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
    assign last_vec  = (vec_q == VEC_LAST);

`ifdef ALU_VECTOR_DRIVER_STOP_ON_FAIL_EN
    assign stop_fail = |mask;
`else
    assign stop_fail = 1'b0;
`endif

    // Division results are meaningless for a zero divisor, so quo/rem are not compared.
    always_comb begin
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i] = (res_x[32*i +: 32] != res_y[32*i +: 32]);
        end
        if (b_o == '0) begin
            mask[3] = 1'b0;
            mask[4] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= NO_FAIL;
            fm_q    <= '0;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fm_q    <= fm_d;
            drv_q   <= drv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (cnt_q == CNT_LAST) state_d = CHECK;
            CHECK:   state_d = (last_vec || stop_fail) ? DONE : SETTLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        vec_d  = vec_q;
        err_d  = err_q;
        ff_d   = ff_q;
        fm_d   = fm_q;
        drv_d  = drv_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_d = SEED;
                    cnt_d  = '0;
                    vec_d  = '0;
                    err_d  = '0;
                    ff_d   = NO_FAIL;
                    fm_d   = '0;
                    drv_d  = 1'b1;
                end
            end
            SETTLE: cnt_d = cnt_q + 1'b1;
            CHECK: begin
                if (|mask) begin
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    fm_d = mask;
                    if (ff_q == NO_FAIL) ff_d = vec_q;
                end
                if (state_d == SETTLE) begin
                    lfsr_d = lfsr_next;
                    vec_d  = vec_q + 16'd1;
                    cnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // Operands read zero until the first accepted start after reset.
    always_comb begin
        busy       = (state_q == SETTLE) || (state_q == CHECK);
        done       = (state_q == DONE);
        a_o        = drv_q ? lfsr_q[30:0] : '0;
        b_o        = drv_q ? {lfsr_q[15:0], lfsr_q[31:17]} : '0;
        l_o        = drv_q ? lfsr_q[15:0] : '0;
        m_o        = drv_q ? lfsr_q[31:16] : '0;
        vec_idx    = vec_q;
        err_cnt    = err_q;
        first_fail = ff_q;
        fail_mask  = fm_q;
    end
endmodule

// File: tb/tb_alu_vector_driver.sv
// tb_alu_vector_driver: randomized self-checking bench for alu_vector_driver.
// Two instances: default seed run (dut0) and a zero-divisor seed (dut1).
`timescale 1ns/1ps
module tb_alu_vector_driver;
    localparam int          N0    = 4;
    localparam int          S0    = 2;
    localparam logic [31:0] SEED0 = 32'hACE1_0001;
    localparam int          N1    = 1;
    localparam int          S1    = 1;
    localparam logic [31:0] SEED1 = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic [30:0]  a0, b0, a1, b1;
    logic [15:0]  l0, m0, l1, m1;
    logic [255:0] rx0, ry0, rx1, ry1;
    logic         busy0, done0, busy1, done1;
    logic [15:0]  vi0, ec0, ff0, vi1, ec1, ff1;
    logic [7:0]   fm0, fm1;
    logic [7:0]   inj0 [0:N0-1];
    logic [7:0]   inj1 = 8'h00;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [255:0] alu_pack(input logic [30:0] a, input logic [30:0] b);
        logic [31:0] x, y, q, r;
        x = {1'b0, a};
        y = {1'b0, b};
        q = (y == 0) ? 32'hFFFF_FFFF : x / y;
        r = (y == 0) ? x : x % y;
        return {x ^ y, x | y, x & y, r, q, x * y, x - y, x + y};
    endfunction

    function automatic logic [255:0] flip(input logic [7:0] m);
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[32*i+8] = m[i];
        return f;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        return r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
    endfunction

    always_comb begin
        rx0 = alu_pack(a0, b0);
        ry0 = rx0 ^ flip(inj0[vi0[1:0]]);
        rx1 = alu_pack(a1, b1);
        ry1 = rx1 ^ flip(inj1);
    end

    alu_vector_driver #(.NUM_VEC(N0), .SETTLE_CYC(S0), .SEED(SEED0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .a_o(a0), .b_o(b0), .l_o(l0), .m_o(m0),
        .res_x(rx0), .res_y(ry0),
        .busy(busy0), .done(done0), .vec_idx(vi0),
        .err_cnt(ec0), .first_fail(ff0), .fail_mask(fm0)
    );

    alu_vector_driver #(.NUM_VEC(N1), .SETTLE_CYC(S1), .SEED(SEED1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_o(a1), .b_o(b1), .l_o(l1), .m_o(m1),
        .res_x(rx1), .res_y(ry1),
        .busy(busy1), .done(done1), .vec_idx(vi1),
        .err_cnt(ec1), .first_fail(ff1), .fail_mask(fm1)
    );

    // Whole-run model: vector k occupies S0+1 cycles; done is seen in the cycle ending on edge N*(S0+1)+1.
    task automatic run0(input int mid_start);
        logic [31:0] r   [0:N0-1];
        logic [7:0]  eff [0:N0-1];
        logic [30:0] bb;
        logic [7:0]  e_fm;
        int n_eff, tl, e_err, e_ff, k;
        r[0] = SEED0;
        for (int i = 1; i < N0; i++) r[i] = lfsr_step(r[i-1]);
        for (int i = 0; i < N0; i++) begin
            bb = {r[i][15:0], r[i][31:17]};
            eff[i] = inj0[i];
            if (bb == 0) eff[i][4:3] = 2'b00;
        end
        n_eff = N0; e_err = 0; e_ff = 16'hFFFF; e_fm = 8'h00;
        for (int i = 0; i < n_eff; i++) begin
            if (eff[i] != 0) begin
                e_err++;
                e_fm = eff[i];
                if (e_ff == 16'hFFFF) e_ff = i;
`ifdef ALU_VECTOR_DRIVER_STOP_ON_FAIL_EN
                n_eff = i + 1;
`endif
            end
        end
        tl = n_eff * (S0 + 1);
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int e = 0; e <= tl + 1; e++) begin
            k = (e < tl) ? e / (S0 + 1) : n_eff - 1;
            if (e == 0) begin
                checks++;
                if (a0 !== 31'h2CE1_0001) begin
                    errors++; $display("FAIL a_seed got=%h exp=%h", a0, 31'h2CE1_0001);
                end
            end
            checks++;
            if ({a0, b0, l0, m0} !== {r[k][30:0], r[k][15:0], r[k][31:17], r[k][15:0], r[k][31:16]}) begin
                errors++; $display("FAIL operands e=%0d got=%h/%h/%h/%h exp_r=%h", e, a0, b0, l0, m0, r[k]);
            end
            checks++;
            if (vi0 !== 16'(k)) begin
                errors++; $display("FAIL vec_idx e=%0d got=%0d exp=%0d", e, vi0, k);
            end
            checks++;
            if (busy0 !== (e < tl)) begin
                errors++; $display("FAIL busy e=%0d got=%b exp=%b", e, busy0, e < tl);
            end
            checks++;
            if (done0 !== (e == tl)) begin
                errors++; $display("FAIL done e=%0d got=%b exp=%b", e, done0, e == tl);
            end
            if (e >= tl) begin
                checks++;
                if ({ec0, ff0, fm0} !== {16'(e_err), 16'(e_ff), e_fm}) begin
                    errors++;
                    $display("FAIL result e=%0d got err=%0d ff=%h fm=%h exp err=%0d ff=%h fm=%h",
                             e, ec0, ff0, fm0, e_err, 16'(e_ff), e_fm);
                end
            end
            start0 = (e == mid_start);
            @(negedge clk);
        end
        start0 = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a0, b0, l0, m0} !== '0) begin
            errors++; $display("FAIL reset_operands got=%h/%h/%h/%h exp=0", a0, b0, l0, m0);
        end
        checks++;
        if ({busy0, done0, vi0, ec0, ff0, fm0} !== {2'b00, 16'h0, 16'h0, 16'hFFFF, 8'h00}) begin
            errors++;
            $display("FAIL reset_status got busy=%b done=%b vi=%h ec=%h ff=%h fm=%h",
                     busy0, done0, vi0, ec0, ff0, fm0);
        end
        checks++;
        if ({busy1, done1, ff1} !== {2'b00, 16'hFFFF}) begin
            errors++; $display("FAIL reset_dut1 got busy=%b done=%b ff=%h", busy1, done1, ff1);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_clean();
        for (int i = 0; i < N0; i++) inj0[i] = 8'h00;
        run0(-1);
    endtask

    task automatic test_fault();
        for (int i = 0; i < N0; i++) inj0[i] = 8'h00;
        inj0[2] = 8'h02;
        run0(-1);
        checks++;
        if ({ec0, ff0, fm0} !== {16'd1, 16'd2, 8'h02}) begin
            errors++; $display("FAIL fault_dif got err=%0d ff=%0d fm=%h exp 1/2/02", ec0, ff0, fm0);
        end
    endtask

    task automatic test_back_to_back_start();
        for (int i = 0; i < N0; i++) inj0[i] = 8'h00;
        run0(5);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N0; i++)
                inj0[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            run0(-1);
        end
    endtask

    task automatic test_div_zero(input logic [7:0] inj, input int exp_err, input logic [7:0] exp_fm);
        inj1 = inj;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        checks++;
        if (b1 !== 31'd0 || busy1 !== 1'b1) begin
            errors++; $display("FAIL div0_operand got b=%h busy=%b exp b=0 busy=1", b1, busy1);
        end
        repeat (N1 * (S1 + 1)) @(negedge clk);
        checks++;
        if (done1 !== 1'b1) begin
            errors++; $display("FAIL div0_done got=%b exp=1", done1);
        end
        checks++;
        if ({ec1, ff1, fm1} !== {16'(exp_err), (exp_err != 0) ? 16'd0 : 16'hFFFF, exp_fm}) begin
            errors++;
            $display("FAIL div0_result got err=%0d ff=%h fm=%h exp err=%0d fm=%h",
                     ec1, ff1, fm1, exp_err, exp_fm);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen;
        for (int i = 0; i < N0; i++) inj0[i] = 8'h00;
        inj0[0] = 8'h01;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (S0 + 2) @(negedge clk);
        checks++;
        if ({busy0, vi0, ec0} !== {1'b1, 16'd1, 16'd1}) begin
            errors++; $display("FAIL mid_pre got busy=%b vi=%0d ec=%0d exp 1/1/1", busy0, vi0, ec0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy0, done0, vi0, ec0, ff0, fm0, a0} !== {2'b00, 16'h0, 16'h0, 16'hFFFF, 8'h00, 31'h0}) begin
            errors++;
            $display("FAIL mid_reset got busy=%b done=%b vi=%h ec=%h ff=%h fm=%h a=%h",
                     busy0, done0, vi0, ec0, ff0, fm0, a0);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (N0 * (S0 + 1) + 4) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL mid_no_done got activity=%b exp=0", seen);
        end
    endtask

    task automatic test_stop_on_fail();
        for (int i = 0; i < N0; i++) inj0[i] = 8'h00;
        inj0[1] = 8'h80;
        run0(-1);
        checks++;
`ifdef ALU_VECTOR_DRIVER_STOP_ON_FAIL_EN
        if ({vi0, ec0, ff0} !== {16'd1, 16'd1, 16'd1}) begin
            errors++; $display("FAIL stop_fail got vi=%0d ec=%0d ff=%0d exp 1/1/1", vi0, ec0, ff0);
        end
`else
        if ({vi0, ec0, ff0} !== {16'd3, 16'd1, 16'd1}) begin
            errors++; $display("FAIL stop_fail got vi=%0d ec=%0d ff=%0d exp 3/1/1", vi0, ec0, ff0);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < N0; i++) inj0[i] = 8'h00;
        test_reset();
        test_clean();
        test_fault();
        test_back_to_back_start();
        test_random();
        test_div_zero(8'h18, 0, 8'h00);
        test_div_zero(8'h19, 1, 8'h01);
        test_reset_mid();
        test_stop_on_fail();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
